// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : prog_clock_divider
//  Description : Runtime-programmable clock divider. Produces a registered
//                divided waveform (low phase first, then high phase) and a
//                one-cycle tick on each rising edge of that waveform. New
//                period/high settings arrive over a valid/ready port, wait in
//                a one-entry pending slot and are applied only at a period
//                boundary or while the divider is stopped.
//                Optional macro CLKDIV_CFG_CHECK_EN enables range checking of
//                requests (P >= 2, H >= 1, H < P) with a cfg_err pulse on
//                rejection; without it every handshaken request is captured.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_clock_divider #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 10000000,
    parameter int unsigned DEFAULT_HIGH   = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_def_period = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] c_def_high   = WIDTH'(DEFAULT_HIGH);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_high;
    logic             r_pend_v;
    logic             r_clk_out;
    logic             r_tick;

    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_low_len;
    logic             w_wrap;
    logic             w_next_hi;
    logic             w_hs;
    logic             w_accept;
    logic             w_consume;

    assign w_cnt_inc = r_cnt + c_one;
    assign w_low_len = r_period - r_high;
    assign w_wrap    = (r_cnt == (r_period - c_one));
    assign w_next_hi = (w_cnt_inc >= w_low_len);

    // A handshake needs an empty pending slot.
    assign w_hs      = cfg_valid & ~r_pend_v;

    // The pending slot is drained at every wrap and in every stopped cycle.
    assign w_consume = r_pend_v & (~en | w_wrap);

`ifdef CLKDIV_CFG_CHECK_EN
    logic w_cfg_ok;
    logic r_cfg_err;

    assign w_cfg_ok = (cfg_period >= WIDTH'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
    assign w_accept = w_hs & w_cfg_ok;

    // One-cycle error pulse for each handshaken request that fails the range check.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_hs & ~w_cfg_ok;
        end
    end

    assign cfg_err = r_cfg_err;
`else
    assign w_accept = w_hs;
    assign cfg_err  = 1'b0;
`endif

    // Period counter and registered waveform/tick generation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!en || w_wrap) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_inc;
            r_clk_out <= w_next_hi;
            r_tick    <= w_next_hi & ~r_clk_out;
        end
    end

    // Active settings and pending slot. Consumption and capture are mutually
    // exclusive because a handshake is only possible with the slot empty, so a
    // request captured on a wrap cycle waits for the following boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_period      <= c_def_period;
            r_high        <= c_def_high;
            r_pend_period <= '0;
            r_pend_high   <= '0;
            r_pend_v      <= 1'b0;
        end else if (w_consume) begin
            r_period <= r_pend_period;
            r_high   <= r_pend_high;
            r_pend_v <= 1'b0;
        end else if (w_accept) begin
            r_pend_period <= cfg_period;
            r_pend_high   <= cfg_high;
            r_pend_v      <= 1'b1;
        end
    end

    assign cfg_ready = ~r_pend_v;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;

endmodule
`default_nettype wire

// File: doc/prog_clock_divider.md
# prog_clock_divider

Runtime-programmable clock divider producing a divided clock-enable waveform with configurable period and high time, plus a one-cycle rising-edge tick. It supersedes the fixed 50%-duty divider. Display-scan, debounce and game-timer logic consume `clk_out` or `tick` as slow enables in the system clock domain. A valid/ready configuration port lets a controller retune the rate glitch-free; new settings take effect only at period boundaries.

## Interface
- `WIDTH`, 32: width of the counter and configuration fields.
- `DEFAULT_PERIOD`, 10000000: period in clk cycles after reset; must be ≥2.
- `DEFAULT_HIGH`, 5000000: high-phase length after reset; must satisfy 1 ≤ `DEFAULT_HIGH` < `DEFAULT_PERIOD`.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `en`  in  1  run enable; low = stop and clear.
- `cfg_valid`  in  1  configuration request.
- `cfg_period`  in  WIDTH  requested period P.
- `cfg_high`  in  WIDTH  requested high time H.
- `cfg_ready`  out  1  high when no configuration is pending.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.
- `clk_out`  out  1  divided waveform, registered.
- `tick`  out  1  one-cycle pulse in the cycle `clk_out` first reads 1 in each period.

## Operation
- Active registers:
  - `cnt` (WIDTH bits)
  - `period_r` and `high_r` (active settings)
  - `pend_period`, `pend_high` and `pend_v` (pending slot)
- Reset (`rst`=0 at a clk edge) sets:
  - `cnt`=0, `clk_out`=0, `tick`=0, `cfg_err`=0, `pend_v`=0
  - `period_r`=`DEFAULT_PERIOD`, `high_r`=`DEFAULT_HIGH`
- Waveform: low phase first (P−H cycles), then high phase (H cycles). All comparisons are unsigned.
- Enabled cycle, non-wrap (`cnt` ≠ `period_r`−1):
  - `cnt`←`cnt`+1
  - `clk_out`←(`cnt`+1 ≥ `period_r`−`high_r`)
  - `tick`←1 only when `clk_out` goes 0→1
- Enabled cycle, wrap (`cnt` = `period_r`−1):
  - `cnt`←0, `clk_out`←0, `tick`←0
  - If `pend_v`=1, load `period_r`/`high_r` from the pending slot and clear `pend_v`.
- `en`=0:
  - `cnt`←0, `clk_out`←0, `tick`←0
  - Any pending configuration is applied immediately and `pend_v` cleared.
  - The restart after `en` rises begins with a full low phase.
- `cfg_ready` = !`pend_v`. A handshake is `cfg_valid` & `cfg_ready`.
- Accepted valid request: captured into the pending slot, `pend_v`←1.
- Invalid request (P<2, H=0, or H≥P): not captured; `cfg_err` pulses for 1 cycle; `pend_v` unchanged.
- `cfg_valid` while `cfg_ready`=0: ignored, no error.
- A request handshaken in the same cycle as a wrap is captured only; it applies at the next wrap, or at the next `en`=0 cycle.

## Timing
- `clk_out` and `tick` are registered with no combinational input-to-output path. `cfg_ready` decodes directly from a flop.
- Steady state: `clk_out` period = `period_r` cycles, high for exactly `high_r` cycles. One `tick` per period.
- Configuration latency: a request takes effect after at most `period_r`+1 cycles (handshake cycle, then remaining cycles to the wrap). The in-progress period always completes with the old settings, so there are no runt pulses.
- `cfg_ready` rises the cycle after the pending slot is consumed.
- Reset mid-period: all outputs reach reset values at the reset edge, and the pending slot is discarded.
- `cnt` never exceeds `period_r`−1, so no WIDTH overflow is possible.

## Configuration
- Macro `CLKDIV_CFG_CHECK_EN`.
- Defined: range checking as described; invalid requests are rejected and pulse `cfg_err`.
- Undefined:
  - No checking; every handshaken request is captured.
  - `cfg_err` is tied to 0.
  - Behaviour for P<2 or H≥P is unspecified and the caller is responsible.
  - Saves comparators for area-constrained builds.

## Test plan
All scenarios use WIDTH=8, DEFAULT_PERIOD=4, DEFAULT_HIGH=2.
- Reset, then `en`=1 for 12 cycles → `clk_out` reads 0,0,1,1 repeating (first 1 on the 2nd edge after `en`); `tick` pulses once per 4 cycles, aligned to each 0→1 edge.
- Mid-period, `cfg_valid`=1 with P=5, H=1 → `cfg_ready` drops; the current 4-cycle period completes, then `clk_out` reads 0,0,0,0,1 repeating; `cfg_ready` rises the cycle after the wrap.
- Request P=3, H=3 → `cfg_err` pulses 1 cycle, settings unchanged (macro defined); captured as-is (macro undefined).
- Pending request outstanding plus a second `cfg_valid` → second request ignored and `cfg_err` stays 0; a handshake coinciding with a wrap applies only at the following wrap.
- `en` dropped mid-high-phase with a request pending → next cycle `clk_out`=0 and `cnt`=0, new settings active; on re-enable, the period starts with the new low phase.
- `rst`=0 asserted for one cycle mid-high-phase → `clk_out`, `tick` and `cfg_err` are 0 after that edge, `cfg_ready`=1, and the 4/2 defaults are restored.
